// File: rtl/burst_top.sv
// burst_top: command FSM driving a 16 x 32-bit memory with incrementing,
// wrapping address bursts. Writes land from the accept edge onward; reads
// return one registered word per cycle starting one cycle after accept.
module burst_top (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  input  logic        io_top_wr,
  input  logic        io_top_rd,
  input  logic [3:0]  io_top_address,
  input  logic [3:0]  io_top_length,
  input  logic [31:0] io_top_wdata,
  output logic [31:0] io_top_rdata
);

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   r_len;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_mem [DEPTH];

  logic [AW-1:0]   w_beat_addr;
  logic            w_last_beat;
  logic            w_accept;

  // Current beat address wraps naturally in 4 bits; last beat is cnt == L-1
  assign w_beat_addr = r_addr + r_cnt;
  assign w_last_beat = (r_cnt == (r_len - AW'(1)));
  assign w_accept    = io_start & (io_top_wr | io_top_rd) & (io_top_length != '0);
  assign io_top_rdata = r_rdata;

  // Burst FSM, beat counter, memory and read-data register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_rdata <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= io_top_address;
            r_len  <= io_top_length;
            if (io_top_wr) begin
              // Write wins over read; beat 0 lands on the accept edge
              r_mem[io_top_address] <= io_top_wdata;
              r_cnt   <= AW'(1);
              r_state <= (io_top_length > AW'(1)) ? S_WRITE : S_IDLE;
            end else begin
              r_cnt   <= '0;
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          r_mem[w_beat_addr] <= io_top_wdata;
          r_cnt <= r_cnt + AW'(1);
          if (w_last_beat) begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          r_rdata <= r_mem[w_beat_addr];
          r_cnt   <= r_cnt + AW'(1);
          if (w_last_beat) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_top.sv
// tb_burst_top: directed bursts against a cycle-indexed behavioural model
// plus hand-computed literal read-back expectations.
module tb_burst_top;

  logic        clock;
  logic        reset;
  logic        io_start;
  logic        io_top_wr;
  logic        io_top_rd;
  logic [3:0]  io_top_address;
  logic [3:0]  io_top_length;
  logic [31:0] io_top_wdata;
  logic [31:0] io_top_rdata;

  burst_top dut (
    .clock          (clock),
    .reset          (reset),
    .io_start       (io_start),
    .io_top_wr      (io_top_wr),
    .io_top_rd      (io_top_rd),
    .io_top_address (io_top_address),
    .io_top_length  (io_top_length),
    .io_top_wdata   (io_top_wdata),
    .io_top_rdata   (io_top_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Each accepted command is recorded with its accept cycle; beat effects are
  // derived from (cycle - accept cycle) arithmetic.
  logic [31:0] m_mem [16];
  logic [31:0] m_rdata;
  int cyc = 0;
  int free_at = 0;
  bit wr_act = 0, rd_act = 0;
  int wr_t0, wr_base, wr_len;
  int rd_t0, rd_base, rd_len;
  bit check_en = 0;

  always @(posedge clock) begin
    int k;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      m_rdata = 32'h0;
      wr_act  = 0;
      rd_act  = 0;
      free_at = 0;
    end else begin
      if (cyc >= free_at && io_start && (io_top_wr || io_top_rd) && io_top_length != 4'd0) begin
        if (io_top_wr) begin
          wr_act = 1; wr_t0 = cyc;
          wr_base = int'(io_top_address); wr_len = int'(io_top_length);
          free_at = cyc + wr_len;
        end else begin
          rd_act = 1; rd_t0 = cyc;
          rd_base = int'(io_top_address); rd_len = int'(io_top_length);
          free_at = cyc + rd_len + 1;
        end
      end
      if (wr_act) begin
        k = cyc - wr_t0;
        if (k < wr_len) m_mem[(wr_base + k) % 16] = io_top_wdata;
        else wr_act = 0;
      end
      if (rd_act) begin
        k = cyc - rd_t0;
        if (k >= 1 && k <= rd_len) m_rdata = m_mem[(rd_base + k - 1) % 16];
        else if (k > rd_len) rd_act = 0;
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle model compare ----------------
  int n_vec_m = 0, n_err_m = 0;
  always @(negedge clock) begin
    if (check_en) begin
      n_vec_m++;
      if (io_top_rdata !== m_rdata) begin
        n_err_m++;
        $display("FAIL model_rdata cyc=%0d got=%h exp=%h", cyc, io_top_rdata, m_rdata);
      end
    end
  end

  // ---------------- literal checks and stimulus ----------------
  int n_vec_l = 0, n_err_l = 0;

  task automatic chk(input string name, input logic [31:0] exp);
    n_vec_l++;
    if (io_top_rdata !== exp) begin
      n_err_l++;
      $display("FAIL %s got=%h exp=%h", name, io_top_rdata, exp);
    end
  endtask

  task automatic idle_inputs();
    io_start = 0; io_top_wr = 0; io_top_rd = 0;
    io_top_address = 4'd0; io_top_length = 4'd0; io_top_wdata = 32'h0;
  endtask

  // Called right after a negedge; returns right after the negedge following
  // the last beat edge, so the next command lands on edge T0+L.
  task automatic write_burst(input logic [3:0] a, input logic [3:0] l,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    io_start = 1; io_top_wr = 1; io_top_rd = 0;
    io_top_address = a; io_top_length = l; io_top_wdata = d[0];
    for (int k = 1; k < int'(l); k++) begin
      @(negedge clock);
      io_start = 0; io_top_wr = 0;
      io_top_wdata = d[k];
    end
    @(negedge clock);
    idle_inputs();
  endtask

  // Read with literal per-beat checks; optionally fires a write command
  // during the busy window that must be dropped.
  task automatic read_check(input string name, input logic [3:0] a, input logic [3:0] l,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input bit intrude);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    io_start = 1; io_top_rd = 1; io_top_wr = 0;
    io_top_address = a; io_top_length = l;
    @(negedge clock);
    idle_inputs();
    if (intrude) begin
      io_start = 1; io_top_wr = 1; io_top_address = a;
      io_top_length = 4'd2; io_top_wdata = 32'hBAD0BAD0;
    end
    for (int k = 0; k < int'(l); k++) begin
      @(negedge clock);
      idle_inputs();
      chk($sformatf("%s_beat%0d", name, k), e[k]);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    check_en = 1;
    chk("reset_rdata", 32'h0);
    @(negedge clock);
    chk("idle_rdata", 32'h0);

    read_check("rd3_after_reset", 4'd3, 4'd2, 0, 0, 0, 0, 0);

    write_burst(4'd6, 4'd4, 32'hA, 32'hB, 32'hC, 32'hD);
    read_check("rd6", 4'd6, 4'd4, 32'hA, 32'hB, 32'hC, 32'hD, 0);
    repeat (3) @(negedge clock);
    chk("rdata_hold", 32'hD);

    write_burst(4'd14, 4'd3, 32'h1, 32'h2, 32'h3, 32'h0);
    read_check("rd14_wrap", 4'd14, 4'd3, 32'h1, 32'h2, 32'h3, 0, 0);
    read_check("rd0_wrap", 4'd0, 4'd1, 32'h3, 0, 0, 0, 0);

    // L=0 write: no-op
    io_start = 1; io_top_wr = 1; io_top_address = 4'd6; io_top_length = 4'd0;
    io_top_wdata = 32'hEEEE0000;
    @(negedge clock);
    // write with io_start=0: ignored
    io_start = 0; io_top_wr = 1; io_top_address = 4'd6; io_top_length = 4'd2;
    io_top_wdata = 32'hEEEE0001;
    @(negedge clock);
    idle_inputs();
    read_check("rd6_intrude", 4'd6, 4'd4, 32'hA, 32'hB, 32'hC, 32'hD, 1);
    read_check("rd6_after_ignored", 4'd6, 4'd4, 32'hA, 32'hB, 32'hC, 32'hD, 0);

    // wr and rd together: write wins, rdata untouched
    io_start = 1; io_top_wr = 1; io_top_rd = 1; io_top_address = 4'd5;
    io_top_length = 4'd1; io_top_wdata = 32'h55;
    @(negedge clock);
    idle_inputs();
    chk("prio_rdata_unchanged", 32'hD);
    @(negedge clock);
    chk("prio_rdata_still", 32'hD);
    read_check("rd5_prio", 4'd5, 4'd1, 32'h55, 0, 0, 0, 0);

    // Reset after beat 1 of an L=4 write
    io_start = 1; io_top_wr = 1; io_top_address = 4'd6; io_top_length = 4'd4;
    io_top_wdata = 32'h1111;
    @(negedge clock);
    idle_inputs(); io_top_wdata = 32'h2222;
    @(negedge clock);
    idle_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("midreset_rdata", 32'h0);
    read_check("rd6_after_reset", 4'd6, 4'd4, 0, 0, 0, 0, 0);
    read_check("rd5_after_reset", 4'd5, 4'd1, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec_m + n_vec_l, n_err_m + n_err_l);
    $finish;
  end

endmodule
